// File: rtl/adder_operand_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_operand_serializer_pkg
//  Description : Shared types and constants for the adder operand serializer.
//                Provides the FSM state enumeration, the nibble width and a
//                helper that derives the nibble count from an operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_operand_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    // Number of nibble words emitted per command for a given operand width.
    function automatic int nib_count(input int op_width);
        return op_width / NIBBLE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_operand_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : adder_operand_serializer
//  Description : Pulls one packed operand pair {B, A} per command from a
//                non-FWFT host command FIFO and writes it, most-significant
//                nibble first, into the adder input FIFO as words of the form
//                {zeros, B nibble, A nibble}.
//  Ports       : clock      - single rising-edge clock
//                reset_n    - synchronous active-low reset
//                cmd_empty  - command FIFO empty
//                cmd_rd     - command FIFO read strobe (data next cycle)
//                cmd_din    - command word {B, A}
//                data_full  - adder input FIFO full
//                data_wr    - adder input FIFO write strobe
//                data_dout  - adder input word {zeros, B nib, A nib}
//                busy       - high whenever the FSM is not IDLE
//                ops_done   - count of fully emitted commands (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_operand_serializer
    import adder_operand_serializer_pkg::*;
#(
    parameter int OP_WIDTH   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cmd_empty,
    output logic                    cmd_rd,
    input  logic [2*OP_WIDTH-1:0]   cmd_din,
    input  logic                    data_full,
    output logic                    data_wr,
    output logic [DATA_WIDTH-1:0]   data_dout,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    ops_done
);

    localparam int NIB      = nib_count(OP_WIDTH);
    // A single-nibble operand still needs a 1-bit counter to stay legal.
    localparam int NC_W     = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [NC_W-1:0] LAST_NIB = NC_W'(NIB - 1);

    generate
        if ((OP_WIDTH % NIBBLE_W) != 0 || OP_WIDTH < NIBBLE_W || DATA_WIDTH < 8) begin : g_param_check
            $error("adder_operand_serializer: OP_WIDTH must be a non-zero multiple of 4 and DATA_WIDTH >= 8");
        end
    endgenerate

    state_e                 state_q,    state_d;
    logic [OP_WIDTH-1:0]    a_sh_q,     a_sh_d;
    logic [OP_WIDTH-1:0]    b_sh_q,     b_sh_d;
    logic [NC_W-1:0]        nib_cnt_q,  nib_cnt_d;
    logic [CNT_WIDTH-1:0]   ops_done_q, ops_done_d;

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        nib_cnt_d  = nib_cnt_q;
        ops_done_d = ops_done_q;
        cmd_rd     = 1'b0;
        data_wr    = 1'b0;

        case (state_q)
            IDLE: begin
                // Strobes are gated with reset_n so nothing leaves the block
                // while it is being reset.
                if (!cmd_empty && reset_n) begin
                    cmd_rd  = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                // Non-FWFT FIFO: the word read in IDLE is valid this cycle.
                a_sh_d    = cmd_din[OP_WIDTH-1:0];
                b_sh_d    = cmd_din[2*OP_WIDTH-1:OP_WIDTH];
                nib_cnt_d = '0;
                state_d   = SEND;
            end

            SEND: begin
                if (!data_full && reset_n) begin
                    data_wr   = 1'b1;
                    a_sh_d    = a_sh_q << NIBBLE_W;
                    b_sh_d    = b_sh_q << NIBBLE_W;
                    nib_cnt_d = nib_cnt_q + NC_W'(1);
                    if (nib_cnt_q == LAST_NIB) begin
                        ops_done_d = ops_done_q + CNT_WIDTH'(1);
                        state_d    = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            nib_cnt_q  <= '0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            nib_cnt_q  <= nib_cnt_d;
            ops_done_q <= ops_done_d;
        end
    end

    // The output word always reflects the top nibbles of the shift registers,
    // so it naturally holds while a stall blocks the shift.
    assign data_dout = DATA_WIDTH'({b_sh_q[OP_WIDTH-1 -: NIBBLE_W], a_sh_q[OP_WIDTH-1 -: NIBBLE_W]});
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_done_q;

endmodule
`default_nettype wire

// File: doc/adder_operand_serializer.md
# adder_operand_serializer

Upstream feeder for the nibble adder. It pulls one packed operand pair per command from a host command FIFO and splits it into per-nibble words. It writes those words, most-significant nibble first, into the adder's input FIFO. Each data word carries operand A's nibble in bits [3:0] and operand B's nibble in bits [7:4], which is exactly the format the adder consumes.

## Interface
- OP_WIDTH, 16, operand width in bits; must be a multiple of 4
- DATA_WIDTH, 32, width of the adder input FIFO word
- CNT_WIDTH, 16, width of the completed-operation counter

- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_empty  in  1  command FIFO empty
- cmd_rd  out  1  command FIFO read strobe; data returns the following cycle (non-FWFT)
- cmd_din  in  2*OP_WIDTH  command word {B[OP_WIDTH-1:0], A[OP_WIDTH-1:0]}
- data_full  in  1  adder input FIFO full
- data_wr  out  1  adder input FIFO write strobe
- data_dout  out  DATA_WIDTH  {zeros, B nibble, A nibble}
- busy  out  1  high whenever state ≠ IDLE
- ops_done  out  CNT_WIDTH  number of commands fully emitted; wraps modulo 2^CNT_WIDTH

## Operation
- NIB = OP_WIDTH/4 words are emitted per command.
- States:
  - IDLE: cmd_rd = !cmd_empty, combinational. If cmd_rd=1, go to LOAD.
  - LOAD: capture cmd_din into shift registers a_sh and b_sh. Clear nibble counter nib_cnt. Go to SEND.
  - SEND:
    - data_wr = !data_full, combinational.
    - data_dout = {(DATA_WIDTH-8)'b0, b_sh[OP_WIDTH-1 -: 4], a_sh[OP_WIDTH-1 -: 4]}, driven from registers.
    - On each write: shift a_sh and b_sh left by 4 and increment nib_cnt.
    - On the write with nib_cnt = NIB-1: increment ops_done and go to IDLE.
- data_full=1 in SEND stalls the block: no write, no shift, and data_dout holds its value.
- cmd_rd is never asserted outside IDLE; cmd_empty is ignored in LOAD and SEND.
- data_wr is never asserted outside SEND.
- Bits [DATA_WIDTH-1:8] of data_dout are always 0.

## Timing
- Reset (reset_n=0 at a rising edge) forces:
  - state = IDLE
  - a_sh = 0, b_sh = 0, nib_cnt = 0, ops_done = 0
  - outputs: cmd_rd = 0 (combinational gating of cmd_rd is suppressed while reset_n=0), data_wr = 0, data_dout = 0, busy = 0
- Reset mid-command abandons the remaining nibbles; the partial command does not count toward ops_done.
- Latency with no backpressure, taking cmd_rd at cycle 0:
  - LOAD at cycle 1
  - first data_wr at cycle 2
  - last data_wr at cycle 1+NIB
  - IDLE at cycle 2+NIB, when the next cmd_rd may fire
- Throughput: NIB words per NIB+2 cycles (4 per 6 at default parameters).
- Each data_full=1 cycle in SEND adds exactly one cycle of delay.
- ops_done updates at the same edge as the final shift and is visible the cycle after the last data_wr.
- ops_done wraps from all-ones to 0 with no flag.
- data_full rising in the same cycle as the last nibble: no write that cycle; the block stays in SEND until the write happens.

## Structure
- Shared package holds:
  - state enumeration: IDLE=2'd0, LOAD=2'd1, SEND=2'd2
  - NIBBLE_W=4
  - localparam NIB=OP_WIDTH/NIBBLE_W
- Single flat module with no sub-modules; nib_cnt is $clog2(NIB) bits wide.
- Static assertion: OP_WIDTH % 4 == 0 and DATA_WIDTH >= 8.

## Test plan
- **Basic command:** cmd_din=32'hACF00F35, FIFOs never full.
  - cmd_rd for 1 cycle.
  - data_dout sequence 0xA0, 0xCF, 0xF3, 0x05 on consecutive data_wr cycles 2–5.
  - ops_done=1 and busy=0 at cycle 6.
- **Backpressure:** same command with data_full=1 for cycles 3–4.
  - Word 0xCF is held for 2 extra cycles, then written.
  - The sequence is unchanged and the last write lands at cycle 7.
- **Back-to-back:** two queued commands 0x00010002 and 0xFFFFFFFF.
  - Emits 0x00, 0x00, 0x00, 0x12, then 0xFF ×4.
  - Second cmd_rd occurs exactly at cycle 6.
  - ops_done=2.
- **Empty source:** cmd_empty=1 for 20 cycles.
  - cmd_rd=0, data_wr=0, busy=0 throughout.
- **Mid-command reset:** reset_n=0 during the 2nd word of 0xACF00F35.
  - After the edge, all outputs are 0 and state is IDLE.
  - ops_done=0.
  - A subsequent command emits its full 4-word sequence.
- **Counter wrap:** with CNT_WIDTH=2, run 5 commands.
  - ops_done reads 1, 2, 3, 0, 1.
